// File: rtl/led_bus_if.sv
// LED bank bus between the three pattern requesters and the arbiter.
// The arbiter side uses the master modport; requesters/bench use slave.
interface led_bus_if;
  logic [2:0] req;
  logic [7:0] pat0;
  logic [7:0] pat1;
  logic [7:0] pat2;
  logic [2:0] gnt;
  logic [7:0] LED;
  logic       busy;
  logic       tick;

  modport master (
    input  req, pat0, pat1, pat2,
    output gnt, LED, busy, tick
  );

  modport slave (
    output req, pat0, pat1, pat2,
    input  gnt, LED, busy, tick
  );
endinterface

// File: rtl/led_bus_arbiter.sv
// Round-robin owner of the board LED bank with a minimum hold time in slow
// ticks; one-hot grant, one blank RELEASE cycle between owners.
//
// state   | meaning
// IDLE    | no owner, LED blank, arbitrate on any request
// GRANT   | owner ptr drives LED, hold counter runs on tick
// RELEASE | one cycle, grant dropped, LED holds last pattern
module led_bus_arbiter #(
  parameter logic [23:0] TICK_DIV   = 24'hA00000,
  parameter int          HOLD_TICKS = 4
) (
  input  logic     clk,
  input  logic     reset,
  led_bus_if.master bus
);

  localparam logic [7:0] HOLD_LD = HOLD_TICKS[7:0];

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t      state, state_nxt;
  logic [23:0] cnt, cnt_nxt;
  logic        tick_q;
  logic [7:0]  hc, hc_nxt;
  logic [1:0]  ptr, ptr_nxt;
  logic [2:0]  gnt_q, gnt_nxt;
  logic [7:0]  led_q, led_nxt;

  logic [1:0]  cand1, cand2, winner;
  logic [2:0]  owner_oh;
  logic [7:0]  owner_pat;
  logic        owner_req;
  logic        others_req;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Free-running divider; tick is registered so it is high while cnt==TICK_DIV.
  assign cnt_nxt = (cnt == TICK_DIV) ? 24'd0 : cnt + 24'd1;

  always_comb begin
    cand1  = inc3(ptr);
    cand2  = inc3(cand1);
    winner = ptr;
    if (bus.req[cand1])      winner = cand1;
    else if (bus.req[cand2]) winner = cand2;
  end

  always_comb begin
    owner_oh  = 3'b001 << ptr;
    owner_pat = 8'h00;
    case (ptr)
      2'd0:    owner_pat = bus.pat0;
      2'd1:    owner_pat = bus.pat1;
      2'd2:    owner_pat = bus.pat2;
      default: owner_pat = 8'h00;
    endcase
    owner_req  = |(bus.req & owner_oh);
    others_req = |(bus.req & ~owner_oh);
  end

  always_comb begin
    state_nxt = state;
    hc_nxt    = hc;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt_q;
    led_nxt   = led_q;
    case (state)
      IDLE: begin
        gnt_nxt = 3'b000;
        led_nxt = 8'h00;
        if (|bus.req) begin
          state_nxt = GRANT;
          ptr_nxt   = winner;
          hc_nxt    = HOLD_LD;
          gnt_nxt   = 3'b001 << winner;
        end
      end
      GRANT: begin
        led_nxt = owner_pat;
        gnt_nxt = owner_oh;
        if ((hc == 8'd0) && (!owner_req || others_req)) begin
          state_nxt = RELEASE;
          gnt_nxt   = 3'b000;
        end else if (tick_q && (hc != 8'd0)) begin
          hc_nxt = hc - 8'd1;
        end
      end
      RELEASE: begin
        gnt_nxt   = 3'b000;
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = 3'b000;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 24'd0;
      tick_q <= 1'b0;
      state  <= IDLE;
      hc     <= 8'd0;
      ptr    <= 2'd2;
      gnt_q  <= 3'b000;
      led_q  <= 8'h00;
    end else begin
      cnt    <= cnt_nxt;
      tick_q <= (cnt_nxt == TICK_DIV);
      state  <= state_nxt;
      hc     <= hc_nxt;
      ptr    <= ptr_nxt;
      gnt_q  <= gnt_nxt;
      led_q  <= led_nxt;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.LED  = led_q;
  assign bus.busy = (state != IDLE);
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_led_bus_arbiter.sv
// Scoreboard bench for led_bus_arbiter: stimulus feeds an owner-level model
// and queues expected outputs; a monitor pops and compares every cycle.
module tb_led_bus_arbiter;

  localparam int TDIV = 3;
  localparam int HOLD = 2;

  logic clk;
  logic reset;

  led_bus_if bus ();

  led_bus_arbiter #(.TICK_DIV(24'd3), .HOLD_TICKS(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0] gnt;
    logic [7:0] led;
    logic       busy;
    logic       tick;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   started = 0;

  // Reference model: who owns the LEDs, how many ticks of hold remain,
  // whether we are in the blank hand-over cycle, and where the divider is.
  int         m_owner = -1;
  int         m_last  = 2;
  int         m_hold  = 0;
  int         m_phase = 0;
  bit         m_rel   = 0;
  bit         m_tick  = 0;
  logic [7:0] m_led   = 8'h00;

  task automatic model_edge(input bit r, input logic [2:0] rq,
                            input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2);
    logic [7:0] pats [3];
    bit tick_now;
    bit found;
    pats[0] = p0; pats[1] = p1; pats[2] = p2;
    if (r) begin
      m_owner = -1; m_last = 2; m_hold = 0; m_phase = 0;
      m_rel = 0; m_tick = 0; m_led = 8'h00;
    end else begin
      tick_now = m_tick;
      if (m_rel) begin
        m_rel = 0;
      end else if (m_owner < 0) begin
        m_led = 8'h00;
        found = 0;
        for (int k = 1; k <= 3; k++) begin
          if (!found && rq[(m_last + k) % 3]) begin
            found   = 1;
            m_owner = (m_last + k) % 3;
          end
        end
        if (found) begin
          m_last = m_owner;
          m_hold = HOLD;
        end
      end else begin
        m_led = pats[m_owner];
        if (m_hold == 0 && (!rq[m_owner] || (rq & ~(3'b001 << m_owner)) != 3'b000)) begin
          m_owner = -1;
          m_rel   = 1;
        end else if (tick_now && m_hold > 0) begin
          m_hold--;
        end
      end
      m_phase = (m_phase == TDIV) ? 0 : m_phase + 1;
      m_tick  = (m_phase == TDIV);
    end
  endtask

  task automatic step(input bit r, input logic [2:0] rq, input logic [7:0] p0,
                      input logic [7:0] p1, input logic [7:0] p2);
    exp_t e;
    @(negedge clk);
    reset    = r;
    bus.req  = rq;
    bus.pat0 = p0;
    bus.pat1 = p1;
    bus.pat2 = p2;
    model_edge(r, rq, p0, p1, p2);
    e.gnt  = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
    e.led  = m_led;
    e.busy = (m_owner >= 0) || m_rel;
    e.tick = m_tick;
    q.push_back(e);
    started = 1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: one expected entry per clock edge.
  logic [2:0] prev_gnt = 3'b000;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt",  {5'b0, bus.gnt},  {5'b0, e.gnt});
        chk("led",  bus.LED,          e.led);
        chk("busy", {7'b0, bus.busy}, {7'b0, e.busy});
        chk("tick", {7'b0, bus.tick}, {7'b0, e.tick});
        chk("gnt_onehot", {7'b0, ($countones(bus.gnt) <= 1)}, 8'd1);
        chk("gnt_gap", {7'b0, !(prev_gnt != 3'b000 && bus.gnt != 3'b000 && bus.gnt != prev_gnt)}, 8'd1);
        prev_gnt = bus.gnt;
      end else if (started) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty: got no expectation want one at %0t", $time);
      end
    end
  end

  logic [2:0] rq;
  logic [7:0] p0, p1, p2;

  initial begin
    reset = 1'b1; bus.req = 3'b000;
    bus.pat0 = 8'h00; bus.pat1 = 8'h00; bus.pat2 = 8'h00;

    step(1, 3'b000, 8'h0F, 8'hF0, 8'hC3);
    step(1, 3'b000, 8'h0F, 8'hF0, 8'hC3);

    // Single requester 0, then release to blank.
    for (int i = 0; i < 20; i++) step(0, 3'b001, 8'h0F, 8'hF0, 8'hC3);
    for (int i = 0; i < 10; i++) step(0, 3'b000, 8'h0F, 8'hF0, 8'hC3);

    // All three requesting from reset: rotation 0,1,2,0.
    step(1, 3'b111, 8'h0F, 8'hF0, 8'hC3);
    for (int i = 0; i < 60; i++) step(0, 3'b111, 8'h0F, 8'hF0, 8'hC3);

    // Lone requester 1 keeps the grant; pattern changes track.
    for (int i = 0; i < 50; i++) step(0, 3'b010, 8'h0F, 8'($urandom), 8'hC3);
    for (int i = 0; i < 6; i++)  step(0, 3'b000, 8'h0F, 8'hF0, 8'hC3);

    // Owner 0 drops request immediately; hold still applies.
    step(1, 3'b000, 8'h0F, 8'hF0, 8'hC3);
    for (int i = 0; i < 2; i++)  step(0, 3'b001, 8'h0F, 8'hF0, 8'hC3);
    for (int i = 0; i < 20; i++) step(0, 3'b000, 8'h0F, 8'hF0, 8'hC3);

    // Reset pulse while requester 2 owns the bank.
    for (int i = 0; i < 200 && m_owner != 2; i++) step(0, 3'b111, 8'h0F, 8'hF0, 8'hC3);
    n_cmp++;
    if (m_owner != 2) begin
      n_bad++;
      $display("FAIL wait_owner2: got owner %0d want 2 within 200 cycles", m_owner);
    end
    step(0, 3'b111, 8'h0F, 8'hF0, 8'hC3);
    step(1, 3'b111, 8'h0F, 8'hF0, 8'hC3);
    for (int i = 0; i < 20; i++) step(0, 3'b111, 8'h0F, 8'hF0, 8'hC3);

    // Random traffic with persistent requests and occasional resets.
    rq = 3'b000; p0 = 8'h00; p1 = 8'h00; p2 = 8'h00;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) rq = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) p0 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) p1 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) p2 = 8'($urandom);
      step(($urandom_range(0, 299) == 0), rq, p0, p1, p2);
    end

    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
